// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
//  Shared definitions for the AXI4-Lite memory responder: response codes,
//  read-channel FSM state encoding and a constant-foldable clog2 helper.
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_READ = 2'b01,
        R_RESP = 2'b10
    } rd_state_e;

    // Smallest n with 2**n >= value; usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        while ((32'd1 << result) < value) begin
            result = result + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_lite_wstrb_ram.sv
// ---------------------------------------------------------------------------
// axi_lite_wstrb_ram
//  Simple dual-port word RAM: one write port with byte enables and one
//  registered read port. A read and a write to the same word on the same
//  edge return the old contents (read-first). Contents are never reset.
// Ports
//  clk    : clock
//  we     : write enable, waddr/wdata/wbe : write word index, data, byte enables
//  re     : read enable,  raddr          : read word index
//  rdata  : registered read data, held while re is low
// ---------------------------------------------------------------------------
module axi_lite_wstrb_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_WIDTH-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic                    re,
    input  logic [IDX_WIDTH-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Byte-masked write and registered read; NBA ordering gives read-first.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wbe[b]) begin
                    mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/axi_lite_mem_responder.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_responder
//  AXI4-Lite slave terminating master transactions in an on-chip,
//  byte-strobed word memory. Write (AW/W/B) and read (AR/R) channels are
//  independent. Out-of-range accesses get SLVERR and are counted.
// Ports
//  clk, reset          : clock, asynchronous active-high reset
//  s00_axi_aw*/w*/b*   : write address, write data, write response channels
//  s00_axi_ar*/r*      : read address, read data channels
//  err_count           : saturating count of SLVERR responses on B and R
// ---------------------------------------------------------------------------
module axi_lite_mem_responder
    import axi_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                  s00_axi_awprot,
    input  logic                        s00_axi_awvalid,
    output logic                        s00_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                        s00_axi_wvalid,
    output logic                        s00_axi_wready,
    output logic [1:0]                  s00_axi_bresp,
    output logic                        s00_axi_bvalid,
    input  logic                        s00_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                  s00_axi_arprot,
    input  logic                        s00_axi_arvalid,
    output logic                        s00_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                  s00_axi_rresp,
    output logic                        s00_axi_rvalid,
    input  logic                        s00_axi_rready,
    output logic [15:0]                 err_count
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int LSB        = clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = clog2(MEM_DEPTH);

    function automatic logic [IDX_WIDTH-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return addr[LSB +: IDX_WIDTH];
    endfunction

    // Any address bit above the word index means the word lies past MEM_DEPTH.
    function automatic logic addr_oor(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] hi;
        hi = addr >> (LSB + IDX_WIDTH);
        return |hi;
    endfunction

    // Write path state
    logic                      aw_held_r, w_held_r, awready_r, wready_r;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_r;
    logic [AXI_DATA_WIDTH-1:0] w_data_r;
    logic [STRB_WIDTH-1:0]     w_strb_r;
    logic                      b_pend_r, b_pend_err_r, bvalid_r;
    logic [1:0]                bresp_r;
    logic                      aw_hs_s, w_hs_s, b_hs_s, commit_s, aw_oor_s, ram_we_s;
    logic                      aw_held_nxt_s, w_held_nxt_s;

    // Read path state
    rd_state_e                 state_r, state_nxt_s;
    logic                      arready_r, rvalid_r;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_r;
    logic [AXI_DATA_WIDTH-1:0] rdata_r, ram_rdata_s;
    logic [1:0]                rresp_r;
    logic                      ar_hs_s, ar_oor_s, ram_re_s, load_r_s;

    // Error counter
    logic [15:0]               err_count_r, err_nxt_s;
    logic [1:0]                err_inc_s;
    logic [16:0]               err_sum_s;

    logic                      unused_s;
    assign unused_s = ^{s00_axi_awprot, s00_axi_arprot, aw_addr_r[LSB-1:0], ar_addr_r[LSB-1:0]};

    // Write handshakes, commit decision and next hold occupancy.
    // A commit needs both holds and no response in flight (pending or presented).
    always_comb begin
        aw_hs_s  = s00_axi_awvalid & awready_r;
        w_hs_s   = s00_axi_wvalid & wready_r;
        b_hs_s   = bvalid_r & s00_axi_bready;
        commit_s = aw_held_r & w_held_r & ~bvalid_r & ~b_pend_r;
        aw_oor_s = addr_oor(aw_addr_r);
        ram_we_s = commit_s & ~aw_oor_s;
        if (commit_s) begin
            aw_held_nxt_s = 1'b0;
        end else if (aw_hs_s) begin
            aw_held_nxt_s = 1'b1;
        end else begin
            aw_held_nxt_s = aw_held_r;
        end
        if (commit_s) begin
            w_held_nxt_s = 1'b0;
        end else if (w_hs_s) begin
            w_held_nxt_s = 1'b1;
        end else begin
            w_held_nxt_s = w_held_r;
        end
    end

    // Write holds, registered readies and the B channel register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held_r    <= 1'b0;
            w_held_r     <= 1'b0;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            aw_addr_r    <= {AXI_ADDR_WIDTH{1'b0}};
            w_data_r     <= {AXI_DATA_WIDTH{1'b0}};
            w_strb_r     <= {STRB_WIDTH{1'b0}};
            b_pend_r     <= 1'b0;
            b_pend_err_r <= 1'b0;
            bvalid_r     <= 1'b0;
            bresp_r      <= RESP_OKAY;
        end else begin
            aw_held_r <= aw_held_nxt_s;
            w_held_r  <= w_held_nxt_s;
            awready_r <= ~aw_held_nxt_s;
            wready_r  <= ~w_held_nxt_s;
            if (aw_hs_s) begin
                aw_addr_r <= s00_axi_awaddr;
            end
            if (w_hs_s) begin
                w_data_r <= s00_axi_wdata;
                w_strb_r <= s00_axi_wstrb;
            end
            // Commit edge latches the outcome; the response is presented one edge later.
            if (commit_s) begin
                b_pend_r     <= 1'b1;
                b_pend_err_r <= aw_oor_s;
            end else begin
                b_pend_r <= 1'b0;
            end
            if (b_pend_r) begin
                bvalid_r <= 1'b1;
                bresp_r  <= b_pend_err_r ? RESP_SLVERR : RESP_OKAY;
            end else if (b_hs_s) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read FSM next state and strobes.
    always_comb begin
        state_nxt_s = state_r;
        ram_re_s    = 1'b0;
        load_r_s    = 1'b0;
        ar_hs_s     = s00_axi_arvalid & arready_r;
        ar_oor_s    = addr_oor(ar_addr_r);
        case (state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    state_nxt_s = R_READ;
                end else begin
                    state_nxt_s = R_IDLE;
                end
            end
            R_READ: begin
                ram_re_s    = 1'b1;
                state_nxt_s = R_RESP;
            end
            R_RESP: begin
                // First R_RESP cycle captures RAM output into the R register.
                if (!rvalid_r) begin
                    load_r_s = 1'b1;
                end else if (s00_axi_rready) begin
                    state_nxt_s = R_IDLE;
                end else begin
                    state_nxt_s = R_RESP;
                end
            end
            default: begin
                state_nxt_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state, AR capture and R channel register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= R_IDLE;
            arready_r <= 1'b0;
            ar_addr_r <= {AXI_ADDR_WIDTH{1'b0}};
            rvalid_r  <= 1'b0;
            rdata_r   <= {AXI_DATA_WIDTH{1'b0}};
            rresp_r   <= RESP_OKAY;
        end else begin
            state_r   <= state_nxt_s;
            arready_r <= (state_nxt_s == R_IDLE);
            if (ar_hs_s) begin
                ar_addr_r <= s00_axi_araddr;
            end
            if (load_r_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= ar_oor_s ? {AXI_DATA_WIDTH{1'b0}} : ram_rdata_s;
                rresp_r  <= ar_oor_s ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid_r & s00_axi_rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Saturating error count; B and R SLVERR can land on the same edge.
    always_comb begin
        err_inc_s = {1'b0, b_pend_r & b_pend_err_r} + {1'b0, load_r_s & ar_oor_s};
        err_sum_s = {1'b0, err_count_r} + {15'd0, err_inc_s};
        if (err_sum_s[16]) begin
            err_nxt_s = 16'hFFFF;
        end else begin
            err_nxt_s = err_sum_s[15:0];
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_r <= 16'd0;
        end else begin
            err_count_r <= err_nxt_s;
        end
    end

    axi_lite_wstrb_ram #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (addr_idx(aw_addr_r)),
        .wdata (w_data_r),
        .wbe   (w_strb_r),
        .re    (ram_re_s),
        .raddr (addr_idx(ar_addr_r)),
        .rdata (ram_rdata_s)
    );

    assign s00_axi_awready = awready_r;
    assign s00_axi_wready  = wready_r;
    assign s00_axi_bvalid  = bvalid_r;
    assign s00_axi_bresp   = bresp_r;
    assign s00_axi_arready = arready_r;
    assign s00_axi_rvalid  = rvalid_r;
    assign s00_axi_rdata   = rdata_r;
    assign s00_axi_rresp   = rresp_r;
    assign err_count       = err_count_r;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_mem_responder
//  Directed bench for axi_lite_mem_responder. Expected B/R responses come
//  from a small reference memory and are queued when a request is driven,
//  then popped and compared when the DUT presents the response.
// ---------------------------------------------------------------------------
module tb_axi_lite_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s00_axi_awaddr;
    logic [2:0]  s00_axi_awprot;
    logic        s00_axi_awvalid;
    logic        s00_axi_awready;
    logic [31:0] s00_axi_wdata;
    logic [3:0]  s00_axi_wstrb;
    logic        s00_axi_wvalid;
    logic        s00_axi_wready;
    logic [1:0]  s00_axi_bresp;
    logic        s00_axi_bvalid;
    logic        s00_axi_bready;
    logic [31:0] s00_axi_araddr;
    logic [2:0]  s00_axi_arprot;
    logic        s00_axi_arvalid;
    logic        s00_axi_arready;
    logic [31:0] s00_axi_rdata;
    logic [1:0]  s00_axi_rresp;
    logic        s00_axi_rvalid;
    logic        s00_axi_rready;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    axi_lite_mem_responder #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .MEM_DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s00_axi_awaddr  (s00_axi_awaddr),
        .s00_axi_awprot  (s00_axi_awprot),
        .s00_axi_awvalid (s00_axi_awvalid),
        .s00_axi_awready (s00_axi_awready),
        .s00_axi_wdata   (s00_axi_wdata),
        .s00_axi_wstrb   (s00_axi_wstrb),
        .s00_axi_wvalid  (s00_axi_wvalid),
        .s00_axi_wready  (s00_axi_wready),
        .s00_axi_bresp   (s00_axi_bresp),
        .s00_axi_bvalid  (s00_axi_bvalid),
        .s00_axi_bready  (s00_axi_bready),
        .s00_axi_araddr  (s00_axi_araddr),
        .s00_axi_arprot  (s00_axi_arprot),
        .s00_axi_arvalid (s00_axi_arvalid),
        .s00_axi_arready (s00_axi_arready),
        .s00_axi_rdata   (s00_axi_rdata),
        .s00_axi_rresp   (s00_axi_rresp),
        .s00_axi_rvalid  (s00_axi_rvalid),
        .s00_axi_rready  (s00_axi_rready),
        .err_count       (err_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    logic [1:0]  b_q [$];
    rexp_t       r_q [$];
    logic [31:0] model_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference write: apply strobes when in range and queue the B response.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int unsigned idx;
        idx = addr >> 2;
        if (idx < DEPTH) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
            b_q.push_back(2'b00);
        end else begin
            b_q.push_back(2'b10);
        end
    endtask

    task automatic model_read(input logic [31:0] addr);
        int unsigned idx;
        rexp_t e;
        idx = addr >> 2;
        if (idx < DEPTH) begin
            e.data = model_mem[idx];
            e.resp = 2'b00;
        end else begin
            e.data = 32'd0;
            e.resp = 2'b10;
        end
        r_q.push_back(e);
    endtask

    // Raise the requested valids together, wait for all readies, hold one edge.
    task automatic issue(input bit do_aw, input bit do_w, input bit do_ar,
                         input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] raddr);
        int n;
        n = 0;
        s00_axi_awaddr  = waddr;
        s00_axi_wdata   = wdata;
        s00_axi_wstrb   = strb;
        s00_axi_araddr  = raddr;
        s00_axi_awvalid = do_aw;
        s00_axi_wvalid  = do_w;
        s00_axi_arvalid = do_ar;
        while (((do_aw && s00_axi_awready !== 1'b1) || (do_w && s00_axi_wready !== 1'b1) ||
                (do_ar && s00_axi_arready !== 1'b1)) && n < 50) begin
            tick();
            n++;
        end
        if (do_aw) check("awready", 32'(s00_axi_awready), 32'd1);
        if (do_w)  check("wready",  32'(s00_axi_wready),  32'd1);
        if (do_ar) check("arready", 32'(s00_axi_arready), 32'd1);
        tick();
        s00_axi_awvalid = 1'b0;
        s00_axi_wvalid  = 1'b0;
        s00_axi_arvalid = 1'b0;
    endtask

    task automatic collect_b();
        int n;
        logic [1:0] exp;
        n = 0;
        while (s00_axi_bvalid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("bvalid", 32'(s00_axi_bvalid), 32'd1);
        exp = (b_q.size() > 0) ? b_q.pop_front() : 2'b11;
        check("bresp", 32'(s00_axi_bresp), 32'(exp));
        s00_axi_bready = 1'b1;
        tick();
        s00_axi_bready = 1'b0;
    endtask

    task automatic collect_r(input int hold);
        int n;
        rexp_t e;
        n = 0;
        while (s00_axi_rvalid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("rvalid", 32'(s00_axi_rvalid), 32'd1);
        e = (r_q.size() > 0) ? r_q.pop_front() : '{data: 32'hFFFF_FFFF, resp: 2'b11};
        check("rdata", s00_axi_rdata, e.data);
        check("rresp", 32'(s00_axi_rresp), 32'(e.resp));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rvalid_hold",  32'(s00_axi_rvalid),  32'd1);
            check("rdata_hold",   s00_axi_rdata,        e.data);
            check("arready_hold", 32'(s00_axi_arready), 32'd0);
        end
        s00_axi_rready = 1'b1;
        tick();
        s00_axi_rready = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        model_write(addr, data, strb);
        issue(1'b1, 1'b1, 1'b0, addr, data, strb, 32'd0);
        collect_b();
    endtask

    task automatic read_word(input logic [31:0] addr, input int hold);
        model_read(addr);
        issue(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'h0, addr);
        collect_r(hold);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_awready"}, 32'(s00_axi_awready), 32'd0);
        check({tag, "_wready"},  32'(s00_axi_wready),  32'd0);
        check({tag, "_arready"}, 32'(s00_axi_arready), 32'd0);
        check({tag, "_bvalid"},  32'(s00_axi_bvalid),  32'd0);
        check({tag, "_rvalid"},  32'(s00_axi_rvalid),  32'd0);
        check({tag, "_bresp"},   32'(s00_axi_bresp),   32'd0);
        check({tag, "_rresp"},   32'(s00_axi_rresp),   32'd0);
        check({tag, "_rdata"},   s00_axi_rdata,        32'd0);
        check({tag, "_err"},     32'(err_count),       32'd0);
    endtask

    initial begin
        reset           = 1'b1;
        s00_axi_awaddr  = 32'd0;
        s00_axi_awprot  = 3'd0;
        s00_axi_awvalid = 1'b0;
        s00_axi_wdata   = 32'd0;
        s00_axi_wstrb   = 4'h0;
        s00_axi_wvalid  = 1'b0;
        s00_axi_bready  = 1'b0;
        s00_axi_araddr  = 32'd0;
        s00_axi_arprot  = 3'd0;
        s00_axi_arvalid = 1'b0;
        s00_axi_rready  = 1'b0;

        // Power-on reset and release
        tick(); tick(); tick();
        check_idle_reset("por");
        reset = 1'b0;
        check("por_awready_release", 32'(s00_axi_awready), 32'd0);
        tick();
        check("por_awready_up", 32'(s00_axi_awready), 32'd1);
        check("por_wready_up",  32'(s00_axi_wready),  32'd1);
        check("por_arready_up", 32'(s00_axi_arready), 32'd1);

        // Known contents for the no-change and collision checks
        write_word(32'h0000_0000, 32'h0102_0304, 4'hF);
        write_word(32'h0000_0008, 32'h0000_0000, 4'hF);

        // Full write with AW leading W by three cycles
        model_write(32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        issue(1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'd0, 4'h0, 32'd0);
        tick(); tick(); tick();
        issue(1'b0, 1'b1, 1'b0, 32'd0, 32'hDEAD_BEEF, 4'hF, 32'd0);
        collect_b();
        read_word(32'h0000_0004, 0);

        // Partial strobe, same-cycle AW/W; B appears at the second edge
        model_write(32'h0000_0004, 32'h1122_3344, 4'b0101);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h1122_3344, 4'b0101, 32'd0);
        check("b_lat0", 32'(s00_axi_bvalid), 32'd0);
        tick();
        check("b_lat1", 32'(s00_axi_bvalid), 32'd0);
        tick();
        check("b_lat2", 32'(s00_axi_bvalid), 32'd1);
        collect_b();
        model_read(32'h0000_0004);
        issue(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'h0, 32'h0000_0004);
        check("r_lat0", 32'(s00_axi_rvalid), 32'd0);
        tick();
        check("r_lat1", 32'(s00_axi_rvalid), 32'd0);
        tick();
        check("r_lat2", 32'(s00_axi_rvalid), 32'd1);
        check("partial_rdata", s00_axi_rdata, 32'hDE22_BE44);
        collect_r(0);

        // Out of range write and read
        write_word(32'h0000_0400, 32'hFFFF_FFFF, 4'hF);
        read_word(32'h0000_0000, 0);
        read_word(32'h0000_0400, 0);
        check("oor_err_count", 32'(err_count), 32'd2);

        // B backpressure with a second pair queued behind it
        model_write(32'h0000_0010, 32'hCAFE_F00D, 4'hF);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 32'd0);
        tick(); tick();
        model_write(32'h0000_0014, 32'h0BAD_F00D, 4'hF);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'h0BAD_F00D, 4'hF, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_bvalid",  32'(s00_axi_bvalid),  32'd1);
            check("bp_bresp",   32'(s00_axi_bresp),   32'd0);
            check("bp_awready", 32'(s00_axi_awready), 32'd0);
            check("bp_wready",  32'(s00_axi_wready),  32'd0);
        end
        collect_b();
        collect_b();

        // R backpressure
        read_word(32'h0000_0010, 5);
        read_word(32'h0000_0014, 0);

        // Commit and read issue of the same word on the same edge: old data
        model_read(32'h0000_0008);
        model_write(32'h0000_0008, 32'hA5A5_A5A5, 4'hF);
        issue(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 4'hF, 32'h0000_0008);
        collect_b();
        collect_r(0);
        read_word(32'h0000_0008, 0);

        // SLVERR on B and R on the same edge
        model_write(32'h0000_0800, 32'h1234_5678, 4'hF);
        model_read(32'h0000_0800);
        issue(1'b1, 1'b1, 1'b1, 32'h0000_0800, 32'h1234_5678, 4'hF, 32'h0000_0800);
        tick();
        check("dual_err_before", 32'(err_count), 32'd2);
        tick();
        check("dual_err_after", 32'(err_count), 32'd4);
        collect_b();
        collect_r(0);

        // Reset right after AW/W/AR acceptance: nothing commits or responds
        issue(1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0000_0004);
        reset = 1'b1;
        #1;
        check_idle_reset("mid");
        tick(); tick();
        reset = 1'b0;
        tick();
        check("mid_awready_up", 32'(s00_axi_awready), 32'd1);
        check("mid_arready_up", 32'(s00_axi_arready), 32'd1);
        tick(); tick(); tick();
        check("mid_no_bvalid", 32'(s00_axi_bvalid), 32'd0);
        check("mid_no_rvalid", 32'(s00_axi_rvalid), 32'd0);
        read_word(32'h0000_0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
